// File: rtl/adc_reader_pkg.sv
// Shared types and default geometry for the multi-lane ADC frame reader.
package adc_reader_pkg;

  localparam int unsigned DEF_LANES       = 4;
  localparam int unsigned DEF_CH_PER_LANE = 2;
  localparam int unsigned DEF_SAMPLE_W    = 24;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PUBLISH
  } state_t;

  typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/adc_input_sync.sv
// Two-flop synchroniser for asynchronous ADC pins, with one-cycle rise/fall
// strobes taken against a third history flop.
module adc_input_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= '0;
      level <= '0;
      hist  <= '0;
    end else begin
      meta  <= pins;
      level <= meta;
      hist  <= level;
    end
  end

  assign rise = level & ~hist;
  assign fall = ~level & hist;

endmodule

// File: rtl/adc_frame_reader.sv
// DRDY-framed, DCLK-clocked multi-lane serial ADC reader; publishes whole frames
// atomically. Optional watchdog enabled by ADC_FRAME_READER_TIMEOUT_EN.
module adc_frame_reader
  import adc_reader_pkg::*;
#(
  parameter  int unsigned LANES       = DEF_LANES,
  parameter  int unsigned CH_PER_LANE = DEF_CH_PER_LANE,
  parameter  int unsigned SAMPLE_W    = DEF_SAMPLE_W,
  parameter  int unsigned CNT_W       = 32,
  parameter  int unsigned ERR_W       = 16,
  parameter  int unsigned TIMEOUT_CYC = 1_000_000,
  localparam int unsigned NUM_CH      = LANES * CH_PER_LANE
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic                       drdy_i,
  input  logic                       dclk_i,
  input  logic [LANES-1:0]           din_i,
  output logic signed [SAMPLE_W-1:0] ch_o [NUM_CH],
  output logic                       tick_o,
  output logic [CNT_W-1:0]           frame_cnt_o,
  output logic [ERR_W-1:0]           short_err_cnt_o,
  output logic                       busy_o,
  output logic                       timeout_o
);

  localparam int unsigned FRAME_BITS = CH_PER_LANE * SAMPLE_W;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);

  logic [LANES+1:0] pins, level, rise, fall;
  logic [LANES-1:0] din_s;
  logic             dclk_rise, drdy_fall;

  assign pins = {drdy_i, dclk_i, din_i};

  adc_input_sync #(.WIDTH(LANES + 2)) u_sync (
    .clk   (clk_i),
    .rst_n (reset_i),
    .pins  (pins),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign din_s     = level[LANES-1:0];
  assign dclk_rise = rise[LANES];
  assign drdy_fall = fall[LANES+1];

  logic unused_strobes;
  assign unused_strobes = ^{level[LANES+1:LANES], rise[LANES+1], rise[LANES-1:0], fall[LANES:0]};

  state_t               state, state_next;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 pend;
  logic                 frame_done;
  logic                 start_req;
  logic                 publish;
  logic                 force_idle;
  logic [FRAME_BITS-1:0] sreg [LANES];

  assign frame_done = (bit_cnt == BIT_W'(FRAME_BITS));
  assign start_req  = drdy_fall | pend;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_req && enable_i) state_next = SHIFT;
      SHIFT: begin
        if (force_idle)      state_next = IDLE;
        else if (frame_done) state_next = PUBLISH;
      end
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state == SHIFT);
    publish = (state == PUBLISH);
  end

  // An abort restarts the count in place; the FSM stays in SHIFT for the new frame.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      bit_cnt         <= '0;
      short_err_cnt_o <= '0;
      pend            <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == SHIFT && !frame_done) begin
        if (drdy_fall) begin
          bit_cnt <= '0;
          if (short_err_cnt_o != '1) short_err_cnt_o <= short_err_cnt_o + ERR_W'(1);
        end else if (dclk_rise) begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end

      if (state == IDLE)
        pend <= 1'b0;
      else if (drdy_fall && (publish || frame_done))
        pend <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned l = 0; l < LANES; l++) sreg[l] <= '0;
    end else if (state == SHIFT && !frame_done && !drdy_fall && dclk_rise) begin
      for (int unsigned l = 0; l < LANES; l++)
        sreg[l] <= {sreg[l][FRAME_BITS-2:0], din_s[l]};
    end
  end

  // Slot 0 arrives first, so it ends up in the most significant bits of the lane word.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned c = 0; c < NUM_CH; c++) ch_o[c] <= '0;
      tick_o      <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      tick_o <= publish;
      if (publish) begin
        frame_cnt_o <= frame_cnt_o + CNT_W'(1);
        for (int unsigned l = 0; l < LANES; l++)
          for (int unsigned s = 0; s < CH_PER_LANE; s++)
            ch_o[l*CH_PER_LANE + s] <= sreg[l][FRAME_BITS-1-s*SAMPLE_W -: SAMPLE_W];
      end
    end
  end

`ifdef ADC_FRAME_READER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_hit;

  assign timeout_hit = !drdy_fall && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign force_idle  = timeout_hit;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (drdy_fall)                          wd_cnt <= '0;
      else if (wd_cnt != WD_W'(TIMEOUT_CYC))  wd_cnt <= wd_cnt + WD_W'(1);

      if (publish)          timeout_o <= 1'b0;
      else if (timeout_hit) timeout_o <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign force_idle     = 1'b0;
  assign timeout_o      = 1'b0;
`endif

endmodule
